// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: half-period configuration handshake for clk_div_ctrl.
interface clk_div_ctrl_if #(parameter int CNT_W = 8);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;
    modport master (output cfg_valid, cfg_half, input cfg_ready, cfg_err);
    modport slave (input cfg_valid, cfg_half, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free 50% programmable clock divider with boundary-aligned ratio changes.
// Optional edge_cnt tick counter enabled by CLK_DIV_CTRL_EDGE_CNT_EN.
module clk_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    clk_div_ctrl_if.slave cfg,
    output logic          clk_out,
    output logic          tick,
    output logic          running
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    output logic [15:0]   edge_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, half, half_n, pend, pend_n;
    logic             pend_v, pend_v_n, clk_n, tick_n, acc, last, bnd;
    assign acc  = cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_half != '0;
    assign last = cnt == half - CNT_W'(1);
    assign bnd  = state != IDLE && !clk_out && last;
    // acc implies no pending value, since cfg_ready mirrors !pend_v
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        half_n   = half;
        pend_n   = pend;
        pend_v_n = pend_v;
        clk_n    = clk_out;
        tick_n   = 1'b0;
        if (state == IDLE) begin
            if (acc) half_n = cfg.cfg_half;
            if (en) begin
                state_n = RUN;
                clk_n   = 1'b1;
                tick_n  = 1'b1;
                cnt_n   = '0;
            end
        end else begin
            cnt_n = last ? '0 : cnt + CNT_W'(1);
            clk_n = last ? !clk_out : clk_out;
            if (acc) begin
                pend_n   = cfg.cfg_half;
                pend_v_n = 1'b1;
            end
            if (bnd) begin
                if (pend_v) begin
                    half_n   = pend;
                    pend_v_n = 1'b0;
                end
                if (!en) begin
                    state_n = IDLE;
                    clk_n   = 1'b0;
                    if (acc) begin
                        half_n   = cfg.cfg_half;
                        pend_v_n = 1'b0;
                    end
                end else begin
                    state_n = RUN;
                    tick_n  = 1'b1;
                end
            end else begin
                state_n = en ? RUN : STOPPING;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            half          <= CNT_W'(DEF_HALF);
            pend          <= '0;
            pend_v        <= 1'b0;
            clk_out       <= 1'b0;
            tick          <= 1'b0;
            running       <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            half          <= half_n;
            pend          <= pend_n;
            pend_v        <= pend_v_n;
            clk_out       <= clk_n;
            tick          <= tick_n;
            running       <= state_n == RUN;
            cfg.cfg_ready <= !pend_v_n;
            cfg.cfg_err   <= cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_half == '0;
        end
    end
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) edge_cnt <= '0;
        else if (tick_n) edge_cnt <= edge_cnt + 16'd1;
    end
`endif
endmodule
